div_mem: RTL

Memory responder for the divisor-search controller. It is a 256 x 8 register-file memory on the controller's Addr/Rw/En/Data interface. It self-initialises with a deterministic nonzero divisor table after reset or on request, then serves single-cycle-issue reads with one-cycle latency, and writes. Data is held between reads, so the controller can sample it one or more cycles after issuing a read.

---
 rtl/div_mem_pkg.sv | 25 ++
 rtl/div_mem_fill_gen.sv | 42 ++++
 rtl/div_mem.sv | 119 +++++++++++
 3 files changed

// File: rtl/div_mem_pkg.sv
// Shared definitions for the divisor-table memory responder.
// The fill function is the single source of truth for table contents.
package div_mem_pkg;

    localparam int D_WIDTH_DEF = 8;
    localparam int A_WIDTH_DEF = 8;

    typedef enum logic {
        FILL = 1'b0,
        IDLE = 1'b1
    } state_e;

    // (7*a + 3) mod 256, with zero mapped to one so no divisor is zero
    function automatic logic [D_WIDTH_DEF-1:0] fill_val(
        input logic [A_WIDTH_DEF-1:0] a
    );
        logic [A_WIDTH_DEF+2:0] t;
        t = (A_WIDTH_DEF+3)'(7) * {3'b000, a} + (A_WIDTH_DEF+3)'(3);
        if (t[D_WIDTH_DEF-1:0] == '0) begin
            return D_WIDTH_DEF'(1);
        end
        return t[D_WIDTH_DEF-1:0];
    endfunction

endpackage

// File: rtl/div_mem_fill_gen.sv
// Fill address counter plus table value generator.
// The counter wraps to zero after the last word, ready for the next fill.
module div_mem_fill_gen
    import div_mem_pkg::*;
#(
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int D_WIDTH = D_WIDTH_DEF
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               clr_i,
    input  logic               step_i,
    output logic [A_WIDTH-1:0] addr_o,
    output logic [D_WIDTH-1:0] data_o,
    output logic               last_o
);

    logic [A_WIDTH-1:0] cnt_q;
    logic [A_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (step_i) begin
            cnt_d = cnt_q + A_WIDTH'(1);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign addr_o = cnt_q;
    assign data_o = fill_val(cnt_q);
    assign last_o = &cnt_q;

endmodule

// File: rtl/div_mem.sv
// Divisor-table memory: self-filling 256x8 register file with
// one-cycle registered reads and a held data output.
module div_mem
    import div_mem_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [A_WIDTH-1:0] Addr,
    input  logic               En,
    input  logic               Rw,
    input  logic [D_WIDTH-1:0] WData,
    input  logic               Init,
    output logic [D_WIDTH-1:0] Data,
    output logic               Ready,
    output logic               Err
);

    localparam int DEPTH = 2 ** A_WIDTH;

    state_e             state_q;
    state_e             state_d;
    logic               ready_q;
    logic               ready_d;
    logic               err_q;
    logic               err_d;
    logic [D_WIDTH-1:0] data_q;
    logic [D_WIDTH-1:0] data_d;

    logic [D_WIDTH-1:0] mem [DEPTH];

    logic               mem_we;
    logic [A_WIDTH-1:0] mem_waddr;
    logic [D_WIDTH-1:0] mem_wdata;

    logic [A_WIDTH-1:0] fill_addr;
    logic [D_WIDTH-1:0] fill_data;
    logic               fill_last;
    logic               fill_clr;
    logic               fill_step;

    assign fill_step = (state_q == FILL);
    assign fill_clr  = (state_q == IDLE) && Init;

    div_mem_fill_gen #(
        .A_WIDTH(A_WIDTH),
        .D_WIDTH(D_WIDTH)
    ) u_fill (
        .Clk   (Clk),
        .Rst   (Rst),
        .clr_i (fill_clr),
        .step_i(fill_step),
        .addr_o(fill_addr),
        .data_o(fill_data),
        .last_o(fill_last)
    );

    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        data_d    = data_q;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = Addr;
        mem_wdata = WData;
        unique case (state_q)
            FILL: begin
                // accesses during fill are dropped and flagged
                err_d     = En;
                mem_we    = 1'b1;
                mem_waddr = fill_addr;
                mem_wdata = fill_data;
                if (fill_last) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            IDLE: begin
                if (En && Rw) begin
                    mem_we = 1'b1;
                end
                if (En && !Rw) begin
                    data_d = mem[Addr];
                end
                if (Init) begin
                    state_d = FILL;
                    ready_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= FILL;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we && !Rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign Data  = data_q;
    assign Ready = ready_q;
    assign Err   = err_q;

endmodule
